// File: rtl/risc_ctrl_seq.sv
// rtl/risc_ctrl_seq.sv - 8-phase instruction sequencer and control decoder for the 8-bit RISC core.
// Optional halt-resume input guarded by `ifdef CTRL_RESUME_EN.
module risc_ctrl_seq #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       is_zero,
`ifdef CTRL_RESUME_EN
  input  logic       resume,
`endif
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  phase_e     phase_q, phase_d;
  logic [2:0] wait_q, wait_d;
  logic       halted_q, halted_d;

  always_comb begin
    phase_d  = phase_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    if (halted_q) begin
`ifdef CTRL_RESUME_EN
      if (resume) begin
        halted_d = 1'b0;
        phase_d  = PH_INST_ADDR;
        wait_d   = '0;
      end
`endif
    end else if ((phase_q == PH_INST_FETCH || phase_q == PH_OP_FETCH) && wait_q != '0) begin
      wait_d = wait_q - 3'd1;
    end else begin
      phase_d = phase_e'(phase_q + 3'd1);
      // Stall counter is armed as the phase enters a memory-access phase
      if (phase_d == PH_INST_FETCH || phase_d == PH_OP_FETCH) begin
        wait_d = WAIT_INIT;
      end else begin
        wait_d = '0;
      end
      if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      wait_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
    end
  end

  logic alu_op;
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (!halted_q) begin
      case (phase_q)
        PH_INST_ADDR:  sel = 1'b1;
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_IDLE: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_OP_ADDR:  inc_pc = 1'b1;
        PH_OP_FETCH: rd = alu_op;
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && is_zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: sel = 1'b1;
      endcase
    end
  end

  assign halt  = halted_q;
  assign phase = phase_q;

endmodule
